// File: rtl/arm_banked_regfile_pkg.sv
// Shared types and helpers for the ARM banked register file: modes, physical indices, PSR layout.
// Defines the 4-bit mode encoding (CPSR[3:0]) and the mode -> physical register bank mapping.
package cpu_types_pkg;

    typedef enum logic [3:0] {
        MODE_USR = 4'h0,
        MODE_FIQ = 4'h1,
        MODE_IRQ = 4'h2,
        MODE_SVC = 4'h3,
        MODE_ABT = 4'h7,
        MODE_UND = 4'hB,
        MODE_SYS = 4'hF
    } cpu_mode_t;

    typedef logic [4:0] phys_reg_idx_t;

    typedef struct packed {
        logic f;
        logic s;
        logic x;
        logic c;
    } psr_mask_t;

    localparam int CPSR_N = 31;
    localparam int CPSR_Z = 30;
    localparam int CPSR_C = 29;
    localparam int CPSR_V = 28;
    localparam int CPSR_I = 7;
    localparam int CPSR_F = 6;
    localparam int CPSR_T = 5;

    localparam logic [31:0] CPSR_RESET_VALUE = 32'h0000_00D3;

    function automatic logic is_legal_mode(input logic [3:0] m);
        case (m)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h7, 4'hB, 4'hF: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

    function automatic logic has_spsr(input cpu_mode_t m);
        return !(m == MODE_USR || m == MODE_SYS);
    endfunction

    function automatic logic [2:0] spsr_slot(input cpu_mode_t m);
        case (m)
            MODE_FIQ: return 3'd0;
            MODE_SVC: return 3'd1;
            MODE_ABT: return 3'd2;
            MODE_IRQ: return 3'd3;
            MODE_UND: return 3'd4;
            default:  return 3'd0;
        endcase
    endfunction

    // Layout: 0-7 r0-r7, 8-14 user r8-r14, 15 PC, 16-22 fiq r8-r14, then r13/r14 pairs svc, abt, irq, und.
    function automatic phys_reg_idx_t bank_map(input cpu_mode_t m, input logic [3:0] idx,
                                               input logic force_user);
        cpu_mode_t     em;
        phys_reg_idx_t p;
        em = force_user ? MODE_USR : m;
        p  = {1'b0, idx};
        if (em == MODE_FIQ && idx >= 4'd8 && idx <= 4'd14) begin
            p = {1'b0, idx} + 5'd8;
        end else if (idx == 4'd13 || idx == 4'd14) begin
            case (em)
                MODE_SVC: p = {1'b0, idx} + 5'd10;
                MODE_ABT: p = {1'b0, idx} + 5'd12;
                MODE_IRQ: p = {1'b0, idx} + 5'd14;
                MODE_UND: p = {1'b0, idx} + 5'd16;
                default:  p = {1'b0, idx};
            endcase
        end
        return p;
    endfunction

endpackage

// File: rtl/arm_banked_regfile_if.sv
// Register-file access bundle: read/write ports, PC update, PSR control and exception entry.
interface arm_banked_regfile_if #(
    parameter int NUM_RD_PORTS = 3,
    parameter int NUM_WR_PORTS = 2,
    parameter int XLEN         = 32
);
    import cpu_types_pkg::*;

    logic [NUM_RD_PORTS-1:0][3:0]      rd_addr;
    logic [NUM_RD_PORTS-1:0]           rd_user;
    logic [NUM_RD_PORTS-1:0][XLEN-1:0] rd_data;

    logic [NUM_WR_PORTS-1:0]           wr_en;
    logic [NUM_WR_PORTS-1:0][3:0]      wr_addr;
    logic [NUM_WR_PORTS-1:0]           wr_user;
    logic [NUM_WR_PORTS-1:0][XLEN-1:0] wr_data;

    logic                              pc_we;
    logic [XLEN-1:0]                   pc_wdata;
    logic                              cpsr_we;
    psr_mask_t                         cpsr_mask;
    logic [XLEN-1:0]                   cpsr_wdata;
    logic                              spsr_we;
    logic [XLEN-1:0]                   spsr_wdata;
    logic                              exc_req;
    cpu_mode_t                         exc_mode;
    logic [XLEN-1:0]                   exc_lr;
    logic                              restore_cpsr;

    logic [XLEN-1:0]                   cpsr;
    logic [XLEN-1:0]                   spsr;
    cpu_mode_t                         mode;
    logic [XLEN-1:0]                   pc;

    modport master (
        output rd_addr, rd_user, wr_en, wr_addr, wr_user, wr_data,
               pc_we, pc_wdata, cpsr_we, cpsr_mask, cpsr_wdata, spsr_we, spsr_wdata,
               exc_req, exc_mode, exc_lr, restore_cpsr,
        input  rd_data, cpsr, spsr, mode, pc
    );

    modport slave (
        input  rd_addr, rd_user, wr_en, wr_addr, wr_user, wr_data,
               pc_we, pc_wdata, cpsr_we, cpsr_mask, cpsr_wdata, spsr_we, spsr_wdata,
               exc_req, exc_mode, exc_lr, restore_cpsr,
        output rd_data, cpsr, spsr, mode, pc
    );

endinterface

// File: rtl/arm_banked_regfile_map.sv
// Combinational architectural -> physical register index translation for one port.
module arm_reg_bank_map
    import cpu_types_pkg::*;
(
    input  cpu_mode_t     mode_i,
    input  logic [3:0]    idx_i,
    input  logic          force_user_i,
    output phys_reg_idx_t phys_o
);

    assign phys_o = bank_map(mode_i, idx_i, force_user_i);

endmodule

// File: rtl/arm_banked_regfile.sv
// ARM banked register file: 31 physical words, CPSR and five SPSRs, exception entry and restore.
// Optional REGFILE_BYPASS_EN forwards the winning same-cycle GPR/PC write to rd_data.
module arm_banked_regfile
    import cpu_types_pkg::*;
#(
    parameter int NUM_RD_PORTS = 3,
    parameter int NUM_WR_PORTS = 2,
    parameter int XLEN         = 32
) (
    input logic                clk,
    input logic                rst_n,
    arm_banked_regfile_if.slave bus
);

    localparam int NUM_PHYS = 31;

    logic [XLEN-1:0] regs_q [NUM_PHYS];
    logic [XLEN-1:0] regs_d [NUM_PHYS];
    logic [XLEN-1:0] spsr_q [5];
    logic [XLEN-1:0] spsr_d [5];
    logic [XLEN-1:0] cpsr_q, cpsr_d;
    cpu_mode_t       cur_mode;
    logic [2:0]      cur_slot;
    psr_mask_t       mask;
    phys_reg_idx_t   rd_phys [NUM_RD_PORTS];
    phys_reg_idx_t   wr_phys [NUM_WR_PORTS];

    assign cur_mode = cpu_mode_t'(cpsr_q[3:0]);
    assign cur_slot = spsr_slot(cur_mode);

    for (genvar g = 0; g < NUM_RD_PORTS; g++) begin : g_rd_map
        arm_reg_bank_map u_map (
            .mode_i      (cur_mode),
            .idx_i       (bus.rd_addr[g]),
            .force_user_i(bus.rd_user[g]),
            .phys_o      (rd_phys[g])
        );
    end

    for (genvar g = 0; g < NUM_WR_PORTS; g++) begin : g_wr_map
        arm_reg_bank_map u_map (
            .mode_i      (cur_mode),
            .idx_i       (bus.wr_addr[g]),
            .force_user_i(bus.wr_user[g]),
            .phys_o      (wr_phys[g])
        );
    end

    // Later assignments win: PC update, then write ports by ascending index, then the exception LR.
    always_comb begin
        regs_d = regs_q;
        if (bus.pc_we) regs_d[15] = bus.pc_wdata;
        for (int w = 0; w < NUM_WR_PORTS; w++) begin
            if (bus.wr_en[w]) regs_d[wr_phys[w]] = bus.wr_data[w];
        end
        if (bus.exc_req) regs_d[bank_map(bus.exc_mode, 4'd14, 1'b0)] = bus.exc_lr;
    end

    always_comb begin
        for (int r = 0; r < NUM_RD_PORTS; r++) begin
`ifdef REGFILE_BYPASS_EN
            bus.rd_data[r] = regs_d[rd_phys[r]];
`else
            bus.rd_data[r] = regs_q[rd_phys[r]];
`endif
        end
    end

    always_comb begin
        cpsr_d = cpsr_q;
        spsr_d = spsr_q;
        mask   = bus.cpsr_mask;
        if (cur_mode == MODE_USR) begin
            mask.s = 1'b0;
            mask.x = 1'b0;
            mask.c = 1'b0;
        end
        if (bus.spsr_we && has_spsr(cur_mode) && !bus.exc_req) spsr_d[cur_slot] = bus.spsr_wdata;

        if (bus.exc_req) begin
            if (has_spsr(bus.exc_mode)) spsr_d[spsr_slot(bus.exc_mode)] = cpsr_q;
            cpsr_d[3:0]    = bus.exc_mode;
            cpsr_d[CPSR_I] = 1'b1;
            cpsr_d[CPSR_T] = 1'b0;
            if (bus.exc_mode == MODE_FIQ) cpsr_d[CPSR_F] = 1'b1;
        end else if (bus.restore_cpsr && has_spsr(cur_mode)) begin
            cpsr_d = spsr_q[cur_slot];
            if (!is_legal_mode(spsr_q[cur_slot][3:0])) cpsr_d[3:0] = cpsr_q[3:0];
        end else if (bus.cpsr_we) begin
            if (mask.f) cpsr_d[31:24] = bus.cpsr_wdata[31:24];
            if (mask.s) cpsr_d[23:16] = bus.cpsr_wdata[23:16];
            if (mask.x) cpsr_d[15:8]  = bus.cpsr_wdata[15:8];
            if (mask.c) begin
                cpsr_d[7:0] = bus.cpsr_wdata[7:0];
                if (!is_legal_mode(bus.cpsr_wdata[3:0])) cpsr_d[3:0] = cpsr_q[3:0];
            end
        end
        cpsr_d[4] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PHYS; i++) regs_q[i] <= '0;
            for (int i = 0; i < 5; i++) spsr_q[i] <= '0;
            cpsr_q <= XLEN'(CPSR_RESET_VALUE);
        end else begin
            for (int i = 0; i < NUM_PHYS; i++) regs_q[i] <= regs_d[i];
            for (int i = 0; i < 5; i++) spsr_q[i] <= spsr_d[i];
            cpsr_q <= cpsr_d;
        end
    end

    assign bus.cpsr = cpsr_q;
    assign bus.spsr = has_spsr(cur_mode) ? spsr_q[cur_slot] : cpsr_q;
    assign bus.mode = cur_mode;
    assign bus.pc   = regs_q[15];

endmodule

// File: tb/tb_arm_banked_regfile.sv
// Directed bench for arm_banked_regfile: banking, PSR updates, exception entry, async reset.
module tb_arm_banked_regfile;
    import cpu_types_pkg::*;

    localparam int NRD = 3;
    localparam int NWR = 2;
    localparam int XL  = 32;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    arm_banked_regfile_if #(.NUM_RD_PORTS(NRD), .NUM_WR_PORTS(NWR), .XLEN(XL)) bus ();

    arm_banked_regfile #(.NUM_RD_PORTS(NRD), .NUM_WR_PORTS(NWR), .XLEN(XL)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic idle();
        bus.wr_en        = '0;
        bus.wr_user      = '0;
        bus.pc_we        = 1'b0;
        bus.cpsr_we      = 1'b0;
        bus.cpsr_mask    = '0;
        bus.cpsr_wdata   = '0;
        bus.spsr_we      = 1'b0;
        bus.spsr_wdata   = '0;
        bus.exc_req      = 1'b0;
        bus.exc_mode     = MODE_USR;
        bus.exc_lr       = '0;
        bus.restore_cpsr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic set_wr(input int p, input logic [3:0] a, input logic [31:0] d);
        bus.wr_en[p]   = 1'b1;
        bus.wr_addr[p] = a;
        bus.wr_data[p] = d;
    endtask

    task automatic set_cpsr(input logic [3:0] m, input logic [31:0] d);
        bus.cpsr_we    = 1'b1;
        bus.cpsr_mask  = m;
        bus.cpsr_wdata = d;
    endtask

    task automatic rd(input int p, input logic [3:0] a, input logic u);
        bus.rd_addr[p] = a;
        bus.rd_user[p] = u;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.rd_addr = '0;
        bus.rd_user = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.pc_wdata = '0;
        idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;

        // Reset state
        check_val("rst_cpsr", bus.cpsr, 32'h0000_00D3);
        check_val("rst_mode", 32'(bus.mode), 32'h3);
        check_val("rst_pc", bus.pc, 32'h0);
        rd(0, 4'd0, 1'b0); rd(1, 4'd13, 1'b0); rd(2, 4'd15, 1'b0);
        check_val("rst_rd0", bus.rd_data[0], 32'h0);
        check_val("rst_rd1", bus.rd_data[1], 32'h0);
        check_val("rst_rd2", bus.rd_data[2], 32'h0);

        // Banked r13 across SVC / IRQ / SYS
        set_wr(0, 4'd13, 32'h1000); tick();
        set_cpsr(4'b0001, 32'h0000_00D2); tick();
        check_val("irq_mode", 32'(bus.mode), 32'h2);
        set_wr(0, 4'd13, 32'h2000); tick();
        rd(0, 4'd13, 1'b0); rd(1, 4'd13, 1'b1);
        check_val("irq_r13", bus.rd_data[0], 32'h2000);
        check_val("irq_r13_user", bus.rd_data[1], 32'h0);
        set_cpsr(4'b0001, 32'h0000_00DF); tick();
        rd(0, 4'd13, 1'b0);
        check_val("sys_r13", bus.rd_data[0], 32'h0);
        set_cpsr(4'b0001, 32'h0000_00D3); tick();
        rd(0, 4'd13, 1'b0);
        check_val("svc_r13", bus.rd_data[0], 32'h1000);

        // Same-cycle write conflict on r3
        rd(2, 4'd3, 1'b0);
        set_wr(0, 4'd3, 32'hAAAA); set_wr(1, 4'd3, 32'h5555);
        #1;
`ifdef REGFILE_BYPASS_EN
        check_val("r3_bypass", bus.rd_data[2], 32'h5555);
`else
        check_val("r3_nobypass", bus.rd_data[2], 32'h0);
`endif
        tick();
        check_val("r3_conflict", bus.rd_data[2], 32'h5555);

        // Write port beats pc_we; then plain PC update
        bus.pc_we = 1'b1; bus.pc_wdata = 32'h100; set_wr(0, 4'd15, 32'h200); tick();
        check_val("pc_wr_wins", bus.pc, 32'h200);
        bus.pc_we = 1'b1; bus.pc_wdata = 32'h300; tick();
        rd(1, 4'd15, 1'b0);
        check_val("pc_we", bus.pc, 32'h300);
        check_val("rd_r15", bus.rd_data[1], 32'h300);

        // SPSR write, restore, SPSR in SYS
        bus.spsr_we = 1'b1; bus.spsr_wdata = 32'h2000_00DF; tick();
        check_val("spsr_svc", bus.spsr, 32'h2000_00DF);
        bus.restore_cpsr = 1'b1; tick();
        check_val("restore_cpsr", bus.cpsr, 32'h2000_00DF);
        check_val("restore_mode", 32'(bus.mode), 32'hF);
        bus.spsr_we = 1'b1; bus.spsr_wdata = 32'h0000_FFFF; tick();
        check_val("sys_spsr_is_cpsr", bus.spsr, 32'h2000_00DF);

        // FIQ exception entry; concurrent cpsr_we dropped
        set_cpsr(4'b1001, 32'h6000_001F); tick();
        check_val("cpsr_pre_exc", bus.cpsr, 32'h6000_001F);
        bus.exc_req = 1'b1; bus.exc_mode = MODE_FIQ; bus.exc_lr = 32'h0800_0104;
        set_cpsr(4'b1111, 32'h0000_0000); tick();
        check_val("exc_cpsr", bus.cpsr, 32'h6000_00D1);
        check_val("exc_mode", 32'(bus.mode), 32'h1);
        check_val("exc_spsr_fiq", bus.spsr, 32'h6000_001F);
        rd(0, 4'd14, 1'b0); rd(1, 4'd14, 1'b1);
        check_val("fiq_r14", bus.rd_data[0], 32'h0800_0104);
        check_val("user_r14", bus.rd_data[1], 32'h0);

        // exc_lr beats a write port targeting the same LR
        bus.exc_req = 1'b1; bus.exc_mode = MODE_FIQ; bus.exc_lr = 32'hCAFE;
        set_wr(1, 4'd14, 32'hBEEF); tick();
        rd(0, 4'd14, 1'b0);
        check_val("exc_lr_wins", bus.rd_data[0], 32'hCAFE);
        check_val("exc2_spsr", bus.spsr, 32'h6000_00D1);

        // Illegal mode field keeps M; other bits update; bit 4 stays set
        set_cpsr(4'b0001, 32'h0000_0045); tick();
        check_val("illegal_mode", bus.cpsr, 32'h6000_0051);

        // USR: flags only; SPSR reads CPSR; restore ignored
        set_cpsr(4'b0001, 32'h0000_0010); tick();
        check_val("to_usr", bus.cpsr, 32'h6000_0010);
        set_cpsr(4'b1111, 32'hF000_00D3); tick();
        check_val("usr_flags_only", bus.cpsr, 32'hF000_0010);
        check_val("usr_spsr", bus.spsr, 32'hF000_0010);
        bus.restore_cpsr = 1'b1; tick();
        check_val("usr_restore_ign", bus.cpsr, 32'hF000_0010);

        // Async reset in the middle of an exception request
        bus.exc_req = 1'b1; bus.exc_mode = MODE_IRQ; bus.exc_lr = 32'h1234;
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_cpsr", bus.cpsr, 32'h0000_00D3);
        check_val("async_rst_pc", bus.pc, 32'h0);
        check_val("async_rst_spsr", bus.spsr, 32'h0);
        rd(0, 4'd3, 1'b0);
        check_val("async_rst_r3", bus.rd_data[0], 32'h0);
        @(posedge clk); #1;
        check_val("rst_hold_cpsr", bus.cpsr, 32'h0000_00D3);
        idle();
        rst_n = 1'b1;
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arm_banked_regfile.md
ARM_BANKED_REGFILE -- requirements
Module: arm_banked_regfile

Interface
REQ-001 SHALL expose parameter NUM_RD_PORTS, default 3, number of independent architectural read ports (1..4).
REQ-002 SHALL expose parameter NUM_WR_PORTS, default 2, number of architectural write ports (1..3); a higher index wins on conflict.
REQ-003 SHALL expose parameter XLEN, default 32, data width of every register and PSR.
REQ-004 SHALL have one clock and an asynchronous, active-low reset; the ports are clk (input, 1, rising-edge clock), then rst_n (input, 1, async active-low reset).
REQ-005 SHALL have rd_addr (input, NUM_RD_PORTS x 4): architectural register index per read port.
REQ-006 SHALL have rd_user (input, NUM_RD_PORTS x 1): force the user bank for that port (LDM/STM ^).
REQ-007 SHALL have rd_data (output, NUM_RD_PORTS x XLEN): combinational read data.
REQ-008 SHALL have wr_en, wr_addr and wr_user (input, NUM_WR_PORTS x 1/4/1), plus wr_data (input, NUM_WR_PORTS x XLEN).
REQ-009 SHALL have pc_we (input, 1) and pc_wdata (input, XLEN): sequential PC update.
REQ-010 SHALL have cpsr_we (input, 1), cpsr_mask (input, 4: f,s,x,c byte enables) and cpsr_wdata (input, XLEN).
REQ-011 SHALL have spsr_we (input, 1) and spsr_wdata (input, XLEN): write the SPSR of the current mode.
REQ-012 SHALL have exc_req (input, 1), exc_mode (input, cpu_mode_t) and exc_lr (input, XLEN): exception entry.
REQ-013 SHALL have restore_cpsr (input, 1): copy the current SPSR into CPSR.
REQ-014 SHALL have cpsr (output, XLEN), spsr (output, XLEN), mode (output, cpu_mode_t) and pc (output, XLEN).

Function
REQ-015 Storage SHALL be 31 physical words: r0-r7, user r8-r14, PC, fiq r8-r14, and r13/r14 for each of svc, abt, irq and und, plus CPSR and 5 SPSRs.
REQ-016 Read mapping SHALL be combinational: fiq banks r8-r14; svc/abt/irq/und bank r13-r14; usr/sys use the user bank; rd_user or wr_user forces the user bank.
REQ-017 A read of r15 SHALL return the stored PC, with no pipeline offset added.
REQ-018 All writes SHALL take effect on the rising clk edge and SHALL map using the mode held before that edge.
REQ-019 For the same physical register, wr port > pc_we; between write ports, the higher index wins.
REQ-020 PSR-update priority SHALL be exc_req > restore_cpsr > cpsr_we, and the losing PSR requests SHALL be dropped that cycle.
REQ-021 Exception entry SHALL, in one edge: SPSR[exc_mode] <= CPSR; LR[exc_mode] <= exc_lr; CPSR.M <= exc_mode; I <= 1; T <= 0; F <= 1 iff exc_mode is FIQ.
REQ-022 An exc_lr write SHALL beat any same-edge write-port write to the same LR.
REQ-023 restore_cpsr in usr/sys SHALL be ignored.
REQ-024 spsr_we in usr/sys SHALL be ignored.
REQ-025 The spsr output in usr/sys SHALL return the CPSR.
REQ-026 cpsr_we SHALL update only the bytes enabled by cpsr_mask.
REQ-027 In usr mode, mask bits s, x and c SHALL be ignored (flags only).
REQ-028 A mode-field value that is not a legal cpu_mode_t encoding SHALL leave M unchanged while the other enabled bits still update.
REQ-029 CPSR[4] SHALL read as 1 at all times.
REQ-030 The mode output SHALL equal CPSR[3:0], registered, and SHALL be visible the cycle after a change.

Reset
REQ-031 While rst_n is low, all GPRs, banked registers, PC and SPSRs SHALL be 0.
REQ-032 While rst_n is low, CPSR SHALL be 0x000000D3 (svc, I=1, F=1, T=0).
REQ-033 Reset assertion SHALL take effect immediately and asynchronously, and SHALL override any in-flight exception entry.

Configuration
REQ-034 With REGFILE_BYPASS_EN defined, rd_data SHALL forward the winning same-cycle write (wr ports/pc_we/exc_lr) to the same physical register combinationally.
REQ-035 Without REGFILE_BYPASS_EN, rd_data SHALL show only stored values, so a write is visible the next cycle.
REQ-036 Neither setting of REGFILE_BYPASS_EN SHALL alter PSR timing.

Structure
REQ-037 cpu_types_pkg SHALL hold phys_reg_idx_t (5-bit), psr_mask_t, the CPSR bit-position constants (N, Z, C, V, I, F, T), CPSR_RESET_VALUE, and a helper that checks cpu_mode_t legality.
REQ-038 One combinational sub-module, arm_reg_bank_map, SHALL map (mode, index, force_user) to a phys_reg_idx_t and be instantiated once per read and write port.
REQ-039 The remaining logic (storage, PSR update, bypass) SHALL live in the top module.

Verification
REQ-040 Scenario: release reset -> cpsr=0x000000D3, mode=SVC, pc=0, and every rd_data reads 0.
REQ-041 Scenario: in SVC write r13=0x1000, switch to IRQ via cpsr_we (mask c), write r13=0x2000 -> IRQ reads r13=0x2000 and SYS reads r13=0, then return to SVC and read r13=0x1000.
REQ-042 Scenario: CPSR=0x6000001F, exc_req with exc_mode=FIQ and exc_lr=0x08000104 -> CPSR=0x600000D1, SPSR_fiq=0x6000001F, fiq r14=0x08000104.
REQ-043 Scenario: in USR mode, cpsr_we with mask=1111 and data 0xF00000D3 -> CPSR=0xF0000010 (flags only).
REQ-044 Scenario: wr port 0 r3=0xAAAA and port 1 r3=0x5555 in the same cycle -> r3=0x5555; with REGFILE_BYPASS_EN, rd of r3 returns 0x5555 in that same cycle.
REQ-045 Scenario: rst_n pulled low mid-cycle during exc_req -> outputs reach reset values without waiting for a clk edge.
